// File: rtl/mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_master
// Description : Memory BIST master. Writes an address-xor-seed pattern to every
//               word through a valid/ready responder, reads it back, counts
//               mismatches, records the first failing address and flags a
//               responder timeout. Define MEM_BIST_INV_PASS_EN to add a second
//               write/read pass using the inverted pattern.
// Revision    : 1.0  initial release
// ============================================================================
module mem_bist_master #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed,
  output logic                   m_valid,
  output logic                   m_wr_rd,
  output logic [ADDR_SIZE-1:0]   m_addr,
  output logic [WIDTH-1:0]       m_wdata,
  input  logic                   m_ready,
  input  logic [WIDTH-1:0]       m_rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ADDR_SIZE+1:0]   err_cnt,
  output logic [ADDR_SIZE-1:0]   fail_addr,
  output logic                   timeout
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_WRITE  = 3'd1;
  localparam logic [2:0] c_WGAP   = 3'd2;
  localparam logic [2:0] c_READ   = 3'd3;
  localparam logic [2:0] c_RGAP   = 3'd4;
  localparam logic [2:0] c_FINISH = 3'd5;

  localparam logic [ADDR_SIZE-1:0] c_LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] c_ADDR_ONE  = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE+1:0] c_ERR_MAX   = '1;
  localparam logic [ADDR_SIZE+1:0] c_ERR_ONE   = (ADDR_SIZE+2)'(1);
  // Sixteenth wait cycle without m_ready ends the test.
  localparam logic [4:0]           c_WAIT_LAST = 5'd15;

  logic [2:0]           r_state;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]     r_seed;
  logic                 r_valid;
  logic                 r_wr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [ADDR_SIZE+1:0] r_err;
  logic [ADDR_SIZE-1:0] r_fail;
  logic                 r_to;
  logic [4:0]           r_wait;
`ifdef MEM_BIST_INV_PASS_EN
  logic                 r_inv;
`endif

  logic [WIDTH-1:0]     w_addr_ext;
  logic [WIDTH-1:0]     w_pat;
  logic                 w_last;
  logic                 w_mismatch;

  // Fit the address into the data width (zero-extend or truncate).
  generate
    if (WIDTH > ADDR_SIZE) begin : g_addr_pad
      assign w_addr_ext = {{(WIDTH-ADDR_SIZE){1'b0}}, r_addr};
    end else if (WIDTH == ADDR_SIZE) begin : g_addr_eq
      assign w_addr_ext = r_addr;
    end else begin : g_addr_trunc
      assign w_addr_ext = r_addr[WIDTH-1:0];
    end
  endgenerate

  // Pattern for the current address; it is both the write data and the read expectation.
`ifdef MEM_BIST_INV_PASS_EN
  assign w_pat = w_addr_ext ^ r_seed ^ {WIDTH{r_inv}};
`else
  assign w_pat = w_addr_ext ^ r_seed;
`endif

  assign w_last     = (r_addr == c_LAST_ADDR);
  assign w_mismatch = (m_rdata != w_pat);

  assign m_valid   = r_valid;
  assign m_wr_rd   = r_wr;
  assign m_addr    = r_addr;
  assign m_wdata   = (r_valid && r_wr) ? w_pat : '0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_addr = r_fail;
  assign timeout   = r_to;

  // Test sequencer: issues requests, checks read data and tracks status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_addr  <= '0;
      r_seed  <= '0;
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
      r_to    <= 1'b0;
      r_wait  <= '0;
`ifdef MEM_BIST_INV_PASS_EN
      r_inv   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_WRITE;
            r_addr  <= '0;
            r_seed  <= seed;
            r_valid <= 1'b1;
            r_wr    <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
            r_to    <= 1'b0;
            r_wait  <= '0;
`ifdef MEM_BIST_INV_PASS_EN
            r_inv   <= 1'b0;
`endif
          end
        end
        c_WRITE, c_READ: begin
          if (m_ready) begin
            r_valid <= 1'b0;
            r_state <= (r_state == c_WRITE) ? c_WGAP : c_RGAP;
            if ((r_state == c_READ) && w_mismatch) begin
              if (r_err == '0) r_fail <= r_addr;
              if (r_err != c_ERR_MAX) r_err <= r_err + c_ERR_ONE;
            end
          end else if (r_wait == c_WAIT_LAST) begin
            // Responder never answered: abandon the test with a failing result.
            r_to    <= 1'b1;
            r_valid <= 1'b0;
            r_state <= c_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
          end else begin
            r_wait <= r_wait + 5'd1;
          end
        end
        c_WGAP: begin
          r_valid <= 1'b1;
          r_wait  <= '0;
          if (w_last) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_state <= c_READ;
          end else begin
            r_addr  <= r_addr + c_ADDR_ONE;
            r_state <= c_WRITE;
          end
        end
        c_RGAP: begin
          if (w_last) begin
`ifdef MEM_BIST_INV_PASS_EN
            if (!r_inv) begin
              // Second pass with the inverted pattern.
              r_inv   <= 1'b1;
              r_addr  <= '0;
              r_wr    <= 1'b1;
              r_valid <= 1'b1;
              r_wait  <= '0;
              r_state <= c_WRITE;
            end else begin
              r_state <= c_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err == '0) && !r_to;
            end
`else
            r_state <= c_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0) && !r_to;
`endif
          end else begin
            r_addr  <= r_addr + c_ADDR_ONE;
            r_valid <= 1'b1;
            r_wait  <= '0;
            r_state <= c_READ;
          end
        end
        c_FINISH: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
